// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: pulls R-type mul/div out of X, drives the multicycle
// multdiv unit, stalls F/D, and writes the result back. Optional MD_TIMEOUT_EN adds a WAIT abort.
module md_sequencer #(
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned STATUS_MUL = 4,
  parameter int unsigned STATUS_DIV = 5,
  parameter int unsigned STATUS_TMO = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  op_x,
  input  logic [4:0]  alu_op_x,
  input  logic [4:0]  rd_x,
  input  logic        valid_x,
  input  logic [31:0] a_x,
  input  logic [31:0] b_x,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        md_mult,
  output logic        md_div,
  input  logic        md_ready,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        main_wb_active,
  output logic        stall_fd,
  output logic        flush_dx,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        rs_write,
  output logic [31:0] rs_data,
  output logic        busy
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] WB    = 3'd3;
`ifdef MD_TIMEOUT_EN
  localparam logic [2:0] ABORT = 3'd4;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`endif

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("md_sequencer: TIMEOUT must be at least 1");
  end

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic        is_mul;
  logic        is_div;
  logic        trigger;
  logic        wb_commit;
  logic [4:0]  pend_rd;
  logic        pend_mul;
  logic [31:0] pend_result;
  logic        pend_exc;
`ifdef MD_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_expired;
`endif

  // Trigger decode; gated by reset so nothing leaks out while reset is held.
  always_comb begin
    is_mul  = valid_x && (op_x == OP_RTYPE) && (alu_op_x == ALU_MUL);
    is_div  = valid_x && (op_x == OP_RTYPE) && (alu_op_x == ALU_DIV);
    trigger = reset && (state == IDLE) && (is_mul || is_div);
  end

`ifdef MD_TIMEOUT_EN
  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; md_ready takes priority over an expiring timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (trigger) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (md_ready) begin
          state_nxt = WB;
`ifdef MD_TIMEOUT_EN
        end else if (wait_expired) begin
          state_nxt = ABORT;
`endif
        end
      end
      WB:    if (!main_wb_active) state_nxt = IDLE;
`ifdef MD_TIMEOUT_EN
      ABORT: state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, start pulses and result capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      md_a        <= '0;
      md_b        <= '0;
      md_mult     <= 1'b0;
      md_div      <= 1'b0;
      pend_rd     <= '0;
      pend_mul    <= 1'b0;
      pend_result <= '0;
      pend_exc    <= 1'b0;
    end else begin
      md_mult <= trigger && is_mul;
      md_div  <= trigger && is_div;
      if (trigger) begin
        md_a     <= a_x;
        md_b     <= b_x;
        pend_rd  <= rd_x;
        pend_mul <= is_mul;
      end
      if ((state == WAIT) && md_ready) begin
        pend_result <= md_result;
        pend_exc    <= md_exception;
      end
    end
  end

`ifdef MD_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`endif

  // Pipeline control and write ports; the write lands in the first WB cycle the W stage is quiet.
  always_comb begin
    stall_fd  = trigger || (state != IDLE);
    flush_dx  = trigger;
    busy      = (state != IDLE);
    wb_commit = (state == WB) && !main_wb_active;
    wb_en     = wb_commit && !pend_exc && (pend_rd != 5'd0);
    wb_addr   = wb_en ? pend_rd : 5'd0;
    wb_data   = wb_en ? pend_result : 32'd0;
    rs_write  = wb_commit && pend_exc;
    rs_data   = 32'd0;
    if (rs_write) begin
      rs_data = pend_mul ? 32'(STATUS_MUL) : 32'(STATUS_DIV);
    end
`ifdef MD_TIMEOUT_EN
    if (state == ABORT) begin
      rs_write = 1'b1;
      rs_data  = 32'(STATUS_TMO);
    end
`endif
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: a per-cycle vector table plus hand sequences
// for long latency, deferred writeback, rd=0, timeout and mid-operation reset.
module tb_md_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  op_x, alu_op_x, rd_x;
  logic        valid_x;
  logic [31:0] a_x, b_x;
  logic [31:0] md_a, md_b;
  logic        md_mult, md_div;
  logic        md_ready;
  logic [31:0] md_result;
  logic        md_exception;
  logic        main_wb_active;
  logic        stall_fd, flush_dx;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rs_write;
  logic [31:0] rs_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  md_sequencer #(.TIMEOUT(8), .STATUS_MUL(4), .STATUS_DIV(5), .STATUS_TMO(6)) dut (
    .clock(clock), .reset(reset), .op_x(op_x), .alu_op_x(alu_op_x), .rd_x(rd_x),
    .valid_x(valid_x), .a_x(a_x), .b_x(b_x), .md_a(md_a), .md_b(md_b),
    .md_mult(md_mult), .md_div(md_div), .md_ready(md_ready), .md_result(md_result),
    .md_exception(md_exception), .main_wb_active(main_wb_active), .stall_fd(stall_fd),
    .flush_dx(flush_dx), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs_write(rs_write), .rs_data(rs_data), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic valid; logic [4:0] op; logic [4:0] alu; logic [4:0] rd;
    logic [31:0] a; logic [31:0] b; logic rdy; logic [31:0] res; logic exc; logic mwb;
    logic e_stall; logic e_flush; logic e_busy; logic e_mult; logic e_div; logic e_wb;
    logic [4:0] e_addr; logic [31:0] e_data; logic e_rs; logic [31:0] e_rsd;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_stall, input logic e_flush,
                          input logic e_busy, input logic e_mult, input logic e_div,
                          input logic e_wb, input logic [4:0] e_addr, input logic [31:0] e_data,
                          input logic e_rs, input logic [31:0] e_rsd);
    chk({tag, ".stall_fd"}, 32'(stall_fd), 32'(e_stall));
    chk({tag, ".flush_dx"}, 32'(flush_dx), 32'(e_flush));
    chk({tag, ".busy"},     32'(busy),     32'(e_busy));
    chk({tag, ".md_mult"},  32'(md_mult),  32'(e_mult));
    chk({tag, ".md_div"},   32'(md_div),   32'(e_div));
    chk({tag, ".wb_en"},    32'(wb_en),    32'(e_wb));
    chk({tag, ".wb_addr"},  32'(wb_addr),  32'(e_addr));
    chk({tag, ".wb_data"},  wb_data,       e_data);
    chk({tag, ".rs_write"}, 32'(rs_write), 32'(e_rs));
    chk({tag, ".rs_data"},  rs_data,       e_rsd);
  endtask

  task automatic idle_in();
    valid_x = 1'b0; op_x = 5'd0; alu_op_x = 5'd0; rd_x = 5'd0; a_x = '0; b_x = '0;
    md_ready = 1'b0; md_result = '0; md_exception = 1'b0; main_wb_active = 1'b0;
  endtask

  // Trigger cycle: drive a live mul/div in X at the negedge and check the same-cycle controls.
  task automatic trig(input string tag, input logic mul, input logic [4:0] rd,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    idle_in();
    valid_x = 1'b1; op_x = 5'b00000; alu_op_x = mul ? 5'b00110 : 5'b00111;
    rd_x = rd; a_x = a; b_x = b;
    #1;
    chk({tag, ".trig_stall"}, 32'(stall_fd), 32'd1);
    chk({tag, ".trig_flush"}, 32'(flush_dx), 32'd1);
  endtask

  initial begin
    int wb_cnt, wb_cyc, rs_cnt;
    tbl[0]  = '{1, 5'd0, 5'd6, 5'd3, 6, 7, 0, 0, 0, 0,          1, 1, 0, 0, 0, 0, 5'd0, 0, 0, 0};
    tbl[1]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 99, 0, 0,         1, 0, 1, 1, 0, 0, 5'd0, 0, 0, 0};
    tbl[2]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 42, 0, 0,         1, 0, 1, 0, 0, 0, 5'd0, 0, 0, 0};
    tbl[3]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0,          1, 0, 1, 0, 0, 1, 5'd3, 42, 0, 0};
    tbl[4]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 77, 0, 0,         0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0};
    tbl[5]  = '{1, 5'd0, 5'd7, 5'd5, 100, 0, 0, 0, 0, 0,        1, 1, 0, 0, 0, 0, 5'd0, 0, 0, 0};
    tbl[6]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0,          1, 0, 1, 0, 1, 0, 5'd0, 0, 0, 0};
    tbl[7]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 32'hdead, 1, 0,   1, 0, 1, 0, 0, 0, 5'd0, 0, 0, 0};
    tbl[8]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1,          1, 0, 1, 0, 0, 0, 5'd0, 0, 0, 0};
    tbl[9]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0,          1, 0, 1, 0, 0, 0, 5'd0, 0, 1, 5};
    tbl[10] = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0};
    tbl[11] = '{0, 5'd0, 5'd6, 5'd2, 1, 1, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0};
    tbl[12] = '{1, 5'd1, 5'd6, 5'd2, 1, 1, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0};
    tbl[13] = '{1, 5'd0, 5'd0, 5'd2, 1, 1, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0};

    // Reset with a live mul in X: everything stays quiet.
    idle_in();
    reset = 1'b0;
    valid_x = 1'b1; alu_op_x = 5'b00110; rd_x = 5'd3; a_x = 6; b_x = 7;
    #2;
    chk_outs("reset", 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    chk("reset.md_a", md_a, 32'd0);
    chk("reset.md_b", md_b, 32'd0);
    repeat (2) @(negedge clock);
    idle_in();
    reset = 1'b1;

    // Per-cycle table: minimum-latency mul, deferred div exception, non-triggers.
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      valid_x = tbl[i].valid; op_x = tbl[i].op; alu_op_x = tbl[i].alu; rd_x = tbl[i].rd;
      a_x = tbl[i].a; b_x = tbl[i].b; md_ready = tbl[i].rdy; md_result = tbl[i].res;
      md_exception = tbl[i].exc; main_wb_active = tbl[i].mwb;
      #1;
      chk_outs($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_flush, tbl[i].e_busy,
               tbl[i].e_mult, tbl[i].e_div, tbl[i].e_wb, tbl[i].e_addr, tbl[i].e_data,
               tbl[i].e_rs, tbl[i].e_rsd);
    end

    // mul rd=3, 6*7, result after 10 cycles: write at T+12, release at T+13.
    trig("lat", 1'b1, 5'd3, 32'd6, 32'd7);
    wb_cnt = 0; wb_cyc = -1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clock);
      idle_in();
      if (c == 11) begin md_ready = 1'b1; md_result = 32'd42; end
      #1;
      if (c == 1) begin
        chk("lat.md_mult", 32'(md_mult), 32'd1);
        chk("lat.md_div", 32'(md_div), 32'd0);
        chk("lat.md_a", md_a, 32'd6);
        chk("lat.md_b", md_b, 32'd7);
      end
      if (c == 2) chk("lat.md_mult_off", 32'(md_mult), 32'd0);
      if (wb_en) begin wb_cnt++; wb_cyc = c; end
      if (c == 12) begin
        chk("lat.wb_addr", 32'(wb_addr), 32'd3);
        chk("lat.wb_data", wb_data, 32'd42);
        chk("lat.stall12", 32'(stall_fd), 32'd1);
      end
      if (c == 13) begin
        chk("lat.stall13", 32'(stall_fd), 32'd0);
        chk("lat.busy13", 32'(busy), 32'd0);
      end
    end
    chk("lat.wb_count", 32'(wb_cnt), 32'd1);
    chk("lat.wb_cycle", 32'(wb_cyc), 32'd12);

    // W stage busy for 3 WB cycles: write deferred exactly 3 cycles.
    trig("defer", 1'b1, 5'd7, 32'd3, 32'd5);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      idle_in();
      if (c == 2) begin md_ready = 1'b1; md_result = 32'h1234_5678; end
      if (c >= 3 && c <= 5) main_wb_active = 1'b1;
      #1;
      if (c >= 3 && c <= 5) begin
        chk($sformatf("defer.c%0d.wb_en", c), 32'(wb_en), 32'd0);
        chk($sformatf("defer.c%0d.stall", c), 32'(stall_fd), 32'd1);
      end
      if (c == 6) chk_outs("defer.c6", 1, 0, 1, 0, 0, 1, 5'd7, 32'h1234_5678, 0, 0);
      if (c == 7) chk_outs("defer.c7", 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    end

    // mul to r0: no write of either kind.
    trig("rd0", 1'b1, 5'd0, 32'd3, 32'd3);
    wb_cnt = 0; rs_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      idle_in();
      if (c == 2) begin md_ready = 1'b1; md_result = 32'd9; end
      #1;
      if (wb_en) wb_cnt++;
      if (rs_write) rs_cnt++;
      if (c == 4) chk("rd0.busy", 32'(busy), 32'd0);
    end
    chk("rd0.wb_count", 32'(wb_cnt), 32'd0);
    chk("rd0.rs_count", 32'(rs_cnt), 32'd0);

    // No md_ready: abort after 8 WAIT cycles, or hang in WAIT without the timeout.
    trig("tmo", 1'b0, 5'd4, 32'd8, 32'd2);
`ifdef MD_TIMEOUT_EN
    rs_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      idle_in();
      #1;
      if (rs_write) rs_cnt++;
      if (c == 10) chk_outs("tmo.c10", 1, 0, 1, 0, 0, 0, 5'd0, 0, 1, 6);
      if (c == 11) chk("tmo.busy11", 32'(busy), 32'd0);
    end
    chk("tmo.rs_count", 32'(rs_cnt), 32'd1);
    trig("rst", 1'b1, 5'd9, 32'd11, 32'd13);
    repeat (3) @(negedge clock);
    idle_in();
`else
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      idle_in();
      #1;
      if (c == 30) begin
        chk("tmo.busy_held", 32'(busy), 32'd1);
        chk("tmo.stall_held", 32'(stall_fd), 32'd1);
        chk("tmo.no_rs", 32'(rs_write), 32'd0);
      end
    end
`endif

    // Asynchronous reset in WAIT, then a stray md_ready must not write.
    #2;
    reset = 1'b0;
    #1;
    chk_outs("rst.async", 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    chk("rst.md_a", md_a, 32'd0);
    chk("rst.md_b", md_b, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    wb_cnt = 0; rs_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      idle_in();
      if (c == 1) begin md_ready = 1'b1; md_result = 32'd55; end
      #1;
      if (wb_en) wb_cnt++;
      if (rs_write) rs_cnt++;
      if (c == 5) chk("rst.busy", 32'(busy), 32'd0);
    end
    chk("rst.wb_count", 32'(wb_cnt), 32'd0);
    chk("rst.rs_count", 32'(rs_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
